// File: rtl/bitmanip_pkg.sv
// Shared constants and helpers for the bitmanip datapath: butterfly masks for the
// generalised zip/unzip network and the single-stage conditional swap.
package bitmanip_pkg;

    typedef enum logic {
        GZIP_ZIP   = 1'b0,
        GZIP_UNZIP = 1'b1
    } gzip_mode_e;

    // Index k selects the stage with shift 2^k; narrower datapaths take the low bits.
    localparam logic [4:0][63:0] GZIP_MASK_L = {
        64'h0000ffff00000000,
        64'h00ff000000ff0000,
        64'h0f000f000f000f00,
        64'h3030303030303030,
        64'h4444444444444444
    };

    localparam logic [4:0][63:0] GZIP_MASK_R = {
        64'h00000000ffff0000,
        64'h0000ff000000ff00,
        64'h00f000f000f000f0,
        64'h0c0c0c0c0c0c0c0c,
        64'h2222222222222222
    };

    function automatic logic [63:0] gzip_stage(
        input logic [63:0] x,
        input logic [63:0] l,
        input logic [63:0] r,
        input int unsigned s
    );
        return (x & ~(l | r)) | ((x << s) & l) | ((x >> s) & r);
    endfunction

endpackage

// File: rtl/gzip_slot.sv
// One butterfly slot: picks its stage from the mode bit, conditionally swaps, and
// either registers the result behind a valid/ready handshake or passes it straight on.
module gzip_slot
    import bitmanip_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int NS    = 4,
    parameter int IDX   = 0,
    parameter int REG   = 1,
    parameter int OUT   = 0
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [XLEN-1:0]          up_data,
    input  logic [$clog2(XLEN)-1:0]  up_ctrl,
    input  logic [TAG_W-1:0]         up_tag,
    output logic                     down_valid,
    input  logic                     down_ready,
    output logic [XLEN-1:0]          down_data,
    output logic [$clog2(XLEN)-1:0]  down_ctrl,
    output logic [TAG_W-1:0]         down_tag
);

    localparam int CW = $clog2(XLEN);
    localparam int SA = IDX;
    localparam int SD = NS - 1 - IDX;
    localparam int unsigned SH_A = 32'd1 << SA;
    localparam int unsigned SH_D = 32'd1 << SD;

    logic [XLEN-1:0] swap_data;

    // Ascending order runs stage IDX here, descending runs the mirrored stage.
    always_comb begin
        swap_data = up_data;
        if (gzip_mode_e'(up_ctrl[0]) == GZIP_UNZIP) begin
            if (up_ctrl[SA+1])
                swap_data = XLEN'(gzip_stage(64'(up_data), GZIP_MASK_L[SA], GZIP_MASK_R[SA], SH_A));
        end else begin
            if (up_ctrl[SD+1])
                swap_data = XLEN'(gzip_stage(64'(up_data), GZIP_MASK_L[SD], GZIP_MASK_R[SD], SH_D));
        end
    end

    generate
        if (REG != 0) begin : g_reg
            logic             valid_reg;
            logic [XLEN-1:0]  data_reg;
            logic [CW-1:0]    ctrl_reg;
            logic [TAG_W-1:0] tag_reg;
            logic             load;

            assign up_ready = !valid_reg || down_ready;
            assign load     = up_valid && up_ready;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn)
                    valid_reg <= 1'b0;
                else if (flush)
                    valid_reg <= 1'b0;
                else if (up_ready)
                    valid_reg <= up_valid;
            end

            // Only the slot driving the unit outputs needs a defined payload after reset.
            if (OUT != 0) begin : g_rst_payload
                always_ff @(posedge clock or negedge resetn) begin
                    if (!resetn) begin
                        data_reg <= '0;
                        ctrl_reg <= '0;
                        tag_reg  <= '0;
                    end else if (load) begin
                        data_reg <= swap_data;
                        ctrl_reg <= up_ctrl;
                        tag_reg  <= up_tag;
                    end
                end
            end else begin : g_payload
                always_ff @(posedge clock) begin
                    if (load) begin
                        data_reg <= swap_data;
                        ctrl_reg <= up_ctrl;
                        tag_reg  <= up_tag;
                    end
                end
            end

            assign down_valid = valid_reg;
            assign down_data  = data_reg;
            assign down_ctrl  = ctrl_reg;
            assign down_tag   = tag_reg;
        end else begin : g_comb
            logic unused_seq;

            assign unused_seq = &{1'b0, clock, resetn, flush};
            assign up_ready   = down_ready;
            assign down_valid = up_valid;
            assign down_data  = swap_data;
            assign down_ctrl  = up_ctrl;
            assign down_tag   = up_tag;
        end
    endgenerate

endmodule

// File: rtl/gzip_pipe.sv
// Pipelined generalised zip/unzip unit: a chain of butterfly slots with valid/ready
// handshaking, a sideband tag and a synchronous flush.
module gzip_pipe
    import bitmanip_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PIPE  = 1,
    parameter int TAG_W = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_data,
    input  logic [$clog2(XLEN)-1:0]  in_ctrl,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int CW = $clog2(XLEN);
    localparam int NS = CW - 1;

    logic             valid_chain [NS+1];
    logic             ready_chain [NS+1];
    logic [XLEN-1:0]  data_chain  [NS+1];
    logic [CW-1:0]    ctrl_chain  [NS+1];
    logic [TAG_W-1:0] tag_chain   [NS+1];
    logic             unused_ctrl;

    assign valid_chain[0]  = in_valid;
    assign data_chain[0]   = in_data;
    assign ctrl_chain[0]   = in_ctrl;
    assign tag_chain[0]    = in_tag;
    assign in_ready        = ready_chain[0];
    assign ready_chain[NS] = out_ready;
    assign out_valid       = valid_chain[NS];
    assign out_data        = data_chain[NS];
    assign out_tag         = tag_chain[NS];
    assign unused_ctrl     = &{1'b0, ctrl_chain[NS]};

    // With PIPE=0 only the final slot registers, giving a single-cycle unit.
    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slot
            gzip_slot #(
                .XLEN  (XLEN),
                .TAG_W (TAG_W),
                .NS    (NS),
                .IDX   (gi),
                .REG   (((PIPE != 0) || (gi == NS - 1)) ? 1 : 0),
                .OUT   ((gi == NS - 1) ? 1 : 0)
            ) u_slot (
                .clock      (clock),
                .resetn     (resetn),
                .flush      (flush),
                .up_valid   (valid_chain[gi]),
                .up_ready   (ready_chain[gi]),
                .up_data    (data_chain[gi]),
                .up_ctrl    (ctrl_chain[gi]),
                .up_tag     (tag_chain[gi]),
                .down_valid (valid_chain[gi+1]),
                .down_ready (ready_chain[gi+1]),
                .down_data  (data_chain[gi+1]),
                .down_ctrl  (ctrl_chain[gi+1]),
                .down_tag   (tag_chain[gi+1])
            );
        end
    endgenerate

endmodule
